// File: rtl/uart_tx.sv
// Purpose : serial UART transmitter; idle-high line, 1 start bit, WIDTH data bits, STOP_BITS stop bits.
// Latency : o_tx drops for the start bit on the cycle after an accepted word when idle.
// Backpress: one-word holding register; o_ready falls while it is full, frames run back-to-back.
//
// Ports:
//   clk          system clock
//   i_reset      synchronous, active-high reset (aborts any frame, discards held word)
//   i_data       word to transmit, sampled on the transfer edge only
//   i_data_valid i_data is valid this cycle; transfer when i_data_valid && o_ready
//   o_ready      block can accept a word (registered, = ~hold_full)
//   o_tx         serial line, driven from a flop
//   o_busy       frame in progress or word pending (registered)
module uart_tx #(
  parameter int WIDTH         = 8,
  parameter int DIVISOR       = 100,
  parameter bit LITTLE_ENDIAN = 1'b0,
  parameter int STOP_BITS     = 1
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_data_valid,
  output logic             o_ready,
  output logic             o_tx,
  output logic             o_busy
);

  localparam int DW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int CW = $clog2(WIDTH + 2);

  localparam logic [DW-1:0] DIV_LAST  = DW'(DIVISOR - 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [DW-1:0]    div_cnt, div_n;
  logic [CW-1:0]    bit_cnt, bit_n;
  logic [WIDTH-1:0] shift_reg, shift_n;
  logic [WIDTH-1:0] hold_reg, hold_n;
  logic             hold_full, full_n;
  logic             tx_q, tx_n;
  logic             ready_q;
  logic             busy_q;
  logic             xfer;
  logic             bit_end;

  assign xfer    = i_data_valid && ready_q;
  assign bit_end = (div_cnt == DIV_LAST);

  always_comb begin
    state_n = state;
    div_n   = div_cnt;
    bit_n   = bit_cnt;
    shift_n = shift_reg;
    hold_n  = hold_reg;
    full_n  = hold_full;
    tx_n    = 1'b1;

    if (state != IDLE) begin
      div_n = bit_end ? '0 : div_cnt + DW'(1);
    end

    // Outside IDLE an accepted word parks in the holding register; since a
    // transfer needs o_ready, the register is known to be empty here.
    if (xfer && (state != IDLE)) begin
      hold_n = i_data;
      full_n = 1'b1;
    end

    case (state)
      IDLE: begin
        if (xfer) begin
          shift_n = i_data;
          state_n = START;
          div_n   = '0;
          bit_n   = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          bit_n   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_n = LITTLE_ENDIAN ? (shift_reg >> 1) : (shift_reg << 1);
          if (bit_cnt == LAST_DATA) begin
            state_n = STOP;
            bit_n   = '0;
          end else begin
            bit_n = bit_cnt + CW'(1);
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_cnt == LAST_STOP) begin
            bit_n = '0;
            if (hold_full) begin
              shift_n = hold_reg;
              full_n  = 1'b0;
              state_n = START;
            end else if (xfer) begin
              // Word arriving on the last stop cycle with nothing held goes
              // straight into the shifter so the next frame starts gap-free.
              shift_n = i_data;
              full_n  = 1'b0;
              state_n = START;
            end else begin
              state_n = IDLE;
            end
          end else begin
            bit_n = bit_cnt + CW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Line level is derived from the next state so the flop holds the value
    // for the whole bit period.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = LITTLE_ENDIAN ? shift_n[0] : shift_n[WIDTH-1];
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      hold_reg  <= '0;
      hold_full <= 1'b0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_n;
      div_cnt   <= div_n;
      bit_cnt   <= bit_n;
      shift_reg <= shift_n;
      hold_reg  <= hold_n;
      hold_full <= full_n;
      tx_q      <= tx_n;
      ready_q   <= ~full_n;
      busy_q    <= (state_n != IDLE) || full_n;
    end
  end

  assign o_ready = ready_q;
  assign o_tx    = tx_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (MSB-first/1 stop, LSB-first/2 stop), DIVISOR=4, WIDTH=8.
// Expected line waveform is a queue of per-cycle samples built from whole frames.
// A mid-bit sampling receiver decodes each line and checks words against the accepted list.
module tb_uart_tx;

  localparam int DIV = 4;

  logic       clk;
  logic       rst;
  logic [7:0] data [2];
  logic       vld  [2];
  logic       rdy  [2];
  logic       tx   [2];
  logic       busy [2];

  int vectors = 0;
  int miscompares = 0;

  bit         acc      [2];
  int         busy_cnt [2];
  int         rlow     [2];
  int         rx_pos   [2];
  logic [7:0] rx_w     [2];

  bit         wq0[$], wq1[$];
  logic [7:0] sq0[$], sq1[$];

  uart_tx #(.WIDTH(8), .DIVISOR(DIV), .LITTLE_ENDIAN(1'b0), .STOP_BITS(1)) u_be (
    .clk(clk), .i_reset(rst), .i_data(data[0]), .i_data_valid(vld[0]),
    .o_ready(rdy[0]), .o_tx(tx[0]), .o_busy(busy[0]));

  uart_tx #(.WIDTH(8), .DIVISOR(DIV), .LITTLE_ENDIAN(1'b1), .STOP_BITS(2)) u_le (
    .clk(clk), .i_reset(rst), .i_data(data[1]), .i_data_valid(vld[1]),
    .o_ready(rdy[1]), .o_tx(tx[1]), .o_busy(busy[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int sb(input int c);   return (c == 0) ? 1 : 2; endfunction
  function automatic bit le(input int c);   return (c == 1);         endfunction
  function automatic int flen(input int c); return (9 + sb(c)) * DIV; endfunction

  function automatic int wsize(input int c); return (c == 0) ? wq0.size() : wq1.size(); endfunction
  function automatic bit wfront(input int c); return (c == 0) ? wq0[0] : wq1[0]; endfunction
  function automatic void wpop(input int c);
    if (c == 0) void'(wq0.pop_front()); else void'(wq1.pop_front());
  endfunction
  function automatic int ssize(input int c); return (c == 0) ? sq0.size() : sq1.size(); endfunction
  function automatic logic [7:0] spop(input int c);
    return (c == 0) ? sq0.pop_front() : sq1.pop_front();
  endfunction
  function automatic void mclear(input int c);
    if (c == 0) begin wq0.delete(); sq0.delete(); end
    else        begin wq1.delete(); sq1.delete(); end
  endfunction

  // Append one whole frame to the expected waveform; frames queue end to end.
  function automatic void push_frame(input int c, input logic [7:0] w);
    bit b;
    for (int k = 0; k < 9 + sb(c); k++) begin
      if (k == 0)      b = 1'b0;
      else if (k <= 8) b = le(c) ? w[k-1] : w[8-k];
      else             b = 1'b1;
      for (int d = 0; d < DIV; d++) begin
        if (c == 0) wq0.push_back(b); else wq1.push_back(b);
      end
    end
    if (c == 0) sq0.push_back(w); else sq1.push_back(w);
  endfunction

  task automatic check(input string nm, input int c, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s ch%0d: got %0h expected %0h", nm, c, act, exp);
    end
  endtask

  // One clock: register handshakes for the coming edge, then compare at negedge.
  task automatic cycle();
    for (int c = 0; c < 2; c++) begin
      acc[c] = ((vld[c] & rdy[c] & ~rst) === 1'b1);
      if (rst) begin
        mclear(c);
        rx_pos[c] = -1;
      end else if (acc[c]) begin
        push_frame(c, data[c]);
      end
    end
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      int n;
      int idx;
      bit e;
      logic [7:0] ew;
      n = wsize(c);
      e = (n > 0) ? wfront(c) : 1'b1;
      check("tx", c, 64'(tx[c]), 64'(e));
      check("busy", c, 64'(busy[c]), 64'(n > 0));
      check("ready", c, 64'(rdy[c]), 64'(n <= flen(c)));
      if (busy[c] === 1'b1) busy_cnt[c]++;
      if (rdy[c] !== 1'b1) rlow[c]++;
      if (n > 0) wpop(c);

      if (rx_pos[c] < 0) begin
        if (tx[c] === 1'b0) rx_pos[c] = 0;
      end else begin
        rx_pos[c]++;
      end
      if (rx_pos[c] >= 0 && rx_pos[c] % DIV == DIV / 2) begin
        idx = rx_pos[c] / DIV;
        if (idx >= 1 && idx <= 8) begin
          if (le(c)) rx_w[c][idx-1] = tx[c];
          else       rx_w[c][8-idx] = tx[c];
        end else if (idx == 9) begin
          check("rx_stop", c, 64'(tx[c]), 64'(1));
          ew = (ssize(c) > 0) ? spop(c) : 8'hxx;
          check("rx_word", c, 64'(rx_w[c]), 64'(ew));
          rx_pos[c] = -1;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic send(input int c, input logic [7:0] w);
    int n;
    n = 0;
    vld[c]  = 1'b1;
    data[c] = w;
    do begin
      cycle();
      n++;
    end while (!acc[c] && n < 200);
    vld[c]  = 1'b0;
    data[c] = 8'($urandom);
    if (!acc[c]) check("send_timeout", c, 64'(acc[c]), 64'(1));
  endtask

  // Collect n line samples starting with the current one, first sample in the MSB.
  task automatic capture(input int c, input int n, output logic [63:0] v);
    v = 64'(tx[c]);
    repeat (n - 1) begin
      cycle();
      v = {v[62:0], tx[c]};
    end
  endtask

  initial begin
    logic [63:0] v;
    int issued [2];
    int guard;

    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      vld[c] = 1'b0; data[c] = 8'h00; busy_cnt[c] = 0; rlow[c] = 0;
      rx_pos[c] = -1; rx_w[c] = 8'h00; issued[c] = 0;
    end
    idle(2);
    rst = 1'b0;
    check("reset_tx", 0, 64'(tx[0]), 64'(1));
    check("reset_ready", 0, 64'(rdy[0]), 64'(1));
    check("reset_busy", 1, 64'(busy[1]), 64'(0));
    busy_cnt[0] = 0;
    idle(50);
    check("idle_busy_cycles", 0, 64'(busy_cnt[0]), 64'(0));

    busy_cnt[0] = 0;
    send(0, 8'hA5);
    capture(0, 40, v);
    check("be_a5_wave", 0, v, 64'h0F0F00F0FF);
    idle(10);
    check("be_a5_busy", 0, 64'(busy_cnt[0]), 64'(40));

    busy_cnt[1] = 0;
    send(1, 8'hA5);
    capture(1, 44, v);
    check("le_a5_wave", 1, v, 64'h0F0F00F0FFF);
    idle(10);
    check("le_a5_busy", 1, 64'(busy_cnt[1]), 64'(44));

    send(0, 8'h01);
    capture(0, 40, v);
    check("be_01_wave", 0, v, 64'h00000000FF);
    send(1, 8'h01);
    capture(1, 44, v);
    check("le_01_wave", 1, v, 64'h0F0000000FF);
    idle(10);

    busy_cnt[0] = 0;
    rlow[0] = 0;
    send(0, 8'h3C);
    send(0, 8'hC3);
    send(0, 8'hFF);
    idle(100);
    check("b2b_busy", 0, 64'(busy_cnt[0]), 64'(120));
    check("b2b_ready_low", 0, 64'(rlow[0]), 64'(78));

    send(0, 8'h55);
    send(0, 8'hAA);
    idle(14);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("midrst_tx", 0, 64'(tx[0]), 64'(1));
    check("midrst_ready", 0, 64'(rdy[0]), 64'(1));
    check("midrst_busy", 0, 64'(busy[0]), 64'(0));
    busy_cnt[0] = 0;
    idle(60);
    check("midrst_no_resend", 0, 64'(busy_cnt[0]), 64'(0));

    guard = 0;
    while ((issued[0] < 256 || issued[1] < 256 || wsize(0) > 0 || wsize(1) > 0 ||
            vld[0] || vld[1]) && guard < 30000) begin
      for (int c = 0; c < 2; c++) begin
        if (vld[c] && acc[c]) begin
          vld[c]  = 1'b0;
          data[c] = 8'($urandom);
        end
        if (!vld[c] && issued[c] < 256 && $urandom_range(0, 3) != 0) begin
          vld[c]  = 1'b1;
          data[c] = 8'($urandom);
          issued[c]++;
        end
      end
      cycle();
      guard++;
    end
    if (guard >= 30000) check("random_timeout", 0, 64'(guard), 64'(0));
    idle(5);
    check("rx_missing", 0, 64'(ssize(0)), 64'(0));
    check("rx_missing", 1, 64'(ssize(1)), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
